text_console_ctrl: RTL and testbench

Clocked, parametrised text-console controller that turns a stream of received bytes into cursor motion and video-RAM character writes. It sits between the UART receiver and the character VRAM. It supports arbitrary column/row geometry, line wrap, backspace, screen clear and hardware scrolling through a ring-buffer row offset that the video scanner reads.

---
 rtl/console_pkg.sv | 15 +
 rtl/text_console_ctrl_if.sv | 27 ++
 rtl/console_addr.sv | 19 +
 rtl/text_console_ctrl.sv | 121 ++++++++++++
 tb/tb_text_console_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/console_pkg.sv
// console_pkg: control codes, FSM states and default geometry shared by the console blocks
package console_pkg;
    localparam int DEF_COLS = 40;
    localparam int DEF_ROWS = 30;
    localparam logic [7:0] C_BS    = 8'h08;
    localparam logic [7:0] C_DEL   = 8'h7F;
    localparam logic [7:0] C_CR    = 8'h0D;
    localparam logic [7:0] C_LF    = 8'h0A;
    localparam logic [7:0] C_FF    = 8'h0C;
    localparam logic [7:0] C_LEFT  = 8'h1C;
    localparam logic [7:0] C_RIGHT = 8'h1D;
    localparam logic [7:0] C_UP    = 8'h1E;
    localparam logic [7:0] C_DOWN  = 8'h1F;
    typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_ROW} state_t;
endpackage

// File: rtl/text_console_ctrl_if.sv
// text_console_ctrl_if: byte stream in, cursor status and VRAM write port out
interface text_console_ctrl_if import console_pkg::*; #(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int X_W    = $clog2(COLS),
    parameter int Y_W    = $clog2(ROWS),
    parameter int ADDR_W = $clog2(COLS * ROWS)
);
    logic              rcv;
    logic [7:0]        data_i;
    logic              busy;
    logic              overrun;
    logic [X_W-1:0]    cursor_x;
    logic [Y_W-1:0]    cursor_y;
    logic [Y_W-1:0]    top_row;
    logic              write;
    logic [ADDR_W-1:0] addr_vram;
    logic [7:0]        character;
    modport master (
        output rcv, data_i,
        input  busy, overrun, cursor_x, cursor_y, top_row, write, addr_vram, character
    );
    modport slave (
        input  rcv, data_i,
        output busy, overrun, cursor_x, cursor_y, top_row, write, addr_vram, character
    );
endinterface

// File: rtl/console_addr.sv
// console_addr: screen (x,y) plus ring offset top to linear VRAM address
module console_addr #(
    parameter int COLS   = 40,
    parameter int ROWS   = 30,
    parameter int X_W    = $clog2(COLS),
    parameter int Y_W    = $clog2(ROWS),
    parameter int ADDR_W = $clog2(COLS * ROWS)
) (
    input  logic [Y_W-1:0]    top,
    input  logic [Y_W-1:0]    y,
    input  logic [X_W-1:0]    x,
    output logic [ADDR_W-1:0] addr
);
    localparam logic [Y_W:0] R = (Y_W + 1)'(ROWS);
    logic [Y_W:0] s, p;
    assign s = {1'b0, top} + {1'b0, y};
    assign p = s >= R ? s - R : s;
    assign addr = ADDR_W'(p[Y_W-1:0]) * ADDR_W'(COLS) + ADDR_W'(x);
endmodule

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: byte stream to cursor motion and VRAM writes with clear/scroll sweeps
// CONSOLE_SCROLL_EN: line feed on the last row scrolls via top_row instead of wrapping to row 0
module text_console_ctrl import console_pkg::*; #(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int X_W    = $clog2(COLS),
    parameter int Y_W    = $clog2(ROWS),
    parameter int ADDR_W = $clog2(COLS * ROWS)
) (
    input logic clk,
    input logic rstn,
    text_console_ctrl_if.slave bus
);
`ifdef CONSOLE_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif
    localparam logic [X_W-1:0]    XMAX = X_W'(COLS - 1);
    localparam logic [Y_W-1:0]    YMAX = Y_W'(ROWS - 1);
    localparam logic [X_W-1:0]    X1   = X_W'(1);
    localparam logic [Y_W-1:0]    Y1   = Y_W'(1);
    localparam logic [ADDR_W-1:0] A1   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] AMAX = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] RMAX = ADDR_W'(COLS - 1);
    state_t            state;
    logic [X_W-1:0]    cx, nx, wx;
    logic [Y_W-1:0]    cy, ny, wy, top, ntop;
    logic [ADDR_W-1:0] cnt, waddr, addr;
    logic [7:0]        d, character;
    logic              pend, acc, prt, bs, ff, lf, wr, scroll, start_row, done, write, overrun;
    assign d   = bus.data_i;
    assign acc = bus.rcv && state == IDLE && !pend;
    assign prt = d >= 8'h20 && d != C_DEL;
    assign bs  = d == C_BS || d == C_DEL;
    assign ff  = d == C_FF;
    always_comb begin
        nx = cx;
        ny = cy;
        lf = 1'b0;
        wr = 1'b0;
        if (prt) begin
            wr = 1'b1;
            nx = cx == XMAX ? '0 : cx + X1;
            lf = cx == XMAX;
        end else if (bs) begin
            wr = cx != '0 || cy != '0;
            nx = cx != '0 ? cx - X1 : cy != '0 ? XMAX : cx;
            ny = cx == '0 && cy != '0 ? cy - Y1 : cy;
        end else if (d == C_CR) begin
            nx = '0;
            lf = 1'b1;
        end else if (d == C_LF) lf = 1'b1;
        else if (d == C_LEFT)  nx = cx == '0 ? XMAX : cx - X1;
        else if (d == C_RIGHT) nx = cx == XMAX ? '0 : cx + X1;
        else if (d == C_UP)    ny = cy == '0 ? YMAX : cy - Y1;
        else if (d == C_DOWN)  ny = cy == YMAX ? '0 : cy + Y1;
        if (lf) ny = cy != YMAX ? cy + Y1 : SCROLL ? cy : '0;
    end
    assign scroll = SCROLL && lf && cy == YMAX;
    assign ntop = scroll ? (top == YMAX ? '0 : top + Y1) : top;
    // A printable byte that scrolls writes itself first; its row clear starts one cycle later via pend
    assign start_row = pend || (acc && scroll && !prt);
    assign wx = start_row ? '0 : bs ? nx : cx;
    assign wy = start_row ? (pend ? YMAX : '0) : bs ? ny : cy;
    assign done = cnt == (state == CLR_ALL ? AMAX : RMAX);
    console_addr #(.COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) u_addr (
        .top(top), .y(wy), .x(wx), .addr(waddr)
    );
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cx        <= '0;
            cy        <= '0;
            top       <= '0;
            cnt       <= '0;
            pend      <= 1'b0;
            write     <= 1'b0;
            addr      <= '0;
            character <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= bus.rcv && !acc;
            if (state != IDLE) begin
                if (done) begin
                    state <= IDLE;
                    write <= 1'b0;
                end else begin
                    cnt   <= cnt + A1;
                    addr  <= addr + A1;
                    write <= 1'b1;
                end
            end else if (pend) begin
                state     <= CLR_ROW;
                pend      <= 1'b0;
                cnt       <= '0;
                write     <= 1'b1;
                addr      <= waddr;
                character <= '0;
            end else if (acc) begin
                state     <= ff ? CLR_ALL : start_row ? CLR_ROW : IDLE;
                cx        <= ff ? '0 : nx;
                cy        <= ff ? '0 : ny;
                top       <= ff ? '0 : ntop;
                pend      <= scroll && prt;
                cnt       <= '0;
                write     <= wr || start_row || ff;
                addr      <= ff ? '0 : waddr;
                character <= prt ? d : '0;
            end else write <= 1'b0;
        end
    end
    assign bus.busy      = state != IDLE;
    assign bus.overrun   = overrun;
    assign bus.cursor_x  = cx;
    assign bus.cursor_y  = cy;
    assign bus.top_row   = top;
    assign bus.write     = write;
    assign bus.addr_vram = addr;
    assign bus.character = character;
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: directed stimulus with a VRAM write scoreboard for text_console_ctrl
module tb_text_console_ctrl;
    import console_pkg::*;
    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int AW = $clog2(COLS * ROWS);
`ifdef CONSOLE_SCROLL_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif
    typedef struct packed {logic [AW-1:0] a; logic [7:0] c;} wr_t;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    wr_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int busy_cnt = 0;
    text_console_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) bus();
    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b);
        bus.rcv = 1'b1;
        bus.data_i = b;
        tick();
        bus.rcv = 1'b0;
    endtask
    task automatic push(input int a, input logic [7:0] c);
        wr_t w;
        w.a = AW'(a);
        w.c = c;
        sb.push_back(w);
    endtask
    task automatic cur(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(bus.cursor_x), x);
        chk({tag, "_y"}, 32'(bus.cursor_y), y);
    endtask
    task automatic wait_idle(input int lim);
        int k = 0;
        while (bus.busy && k < lim) begin
            tick();
            k++;
        end
        chk("busy_timeout", 32'(bus.busy), 0);
    endtask
    always @(negedge clk) begin : mon
        wr_t e;
        if (bus.busy) busy_cnt++;
        if (bus.write) begin
            if (sb.size() == 0) chk("spurious_write", 32'(bus.write), 0);
            else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.addr_vram), 32'(e.a));
                chk("wr_char", 32'(bus.character), 32'(e.c));
            end
        end
    end
    initial begin
        bus.rcv = 1'b0;
        bus.data_i = '0;
        repeat (3) tick();
        cur("rst", 0, 0);
        chk("rst_top", 32'(bus.top_row), 0);
        chk("rst_write", 32'(bus.write), 0);
        chk("rst_addr", 32'(bus.addr_vram), 0);
        chk("rst_char", 32'(bus.character), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ovr", 32'(bus.overrun), 0);
        rstn = 1'b1;
        tick();
        push(0, 8'h41);
        send(8'h41);
        push(1, 8'h42);
        send(8'h42);
        cur("ab", 2, 0);
        chk("ab_busy", 32'(bus.busy), 0);
        repeat (37) send(C_RIGHT);
        chk("right39", 32'(bus.cursor_x), 39);
        push(39, 8'h5A);
        send(8'h5A);
        cur("wrap", 0, 1);
        send(C_UP);
        send(C_BS);
        cur("bs00", 0, 0);
        send(C_DOWN);
        push(39, 8'h00);
        send(C_DEL);
        cur("bs01", 39, 0);
        send(C_UP);
        cur("up_wrap", 39, 29);
        send(C_DOWN);
        cur("down_wrap", 39, 0);
        send(C_RIGHT);
        cur("right_wrap", 0, 0);
        send(C_LEFT);
        cur("left_wrap", 39, 0);
        send(8'h01);
        cur("ignored", 39, 0);
        send(C_LF);
        cur("lf", 39, 1);
        tick();
        chk("sb_empty1", 32'(sb.size()), 0);
        busy_cnt = 0;
        for (int i = 0; i < COLS * ROWS; i++) push(i, 8'h00);
        send(C_FF);
        chk("ff_busy", 32'(bus.busy), 1);
        cur("ff", 0, 0);
        chk("ff_top", 32'(bus.top_row), 0);
        repeat (10) tick();
        bus.rcv = 1'b1;
        bus.data_i = 8'h58;
        tick();
        bus.rcv = 1'b0;
        chk("ovr_pulse", 32'(bus.overrun), 1);
        cur("ovr", 0, 0);
        tick();
        chk("ovr_end", 32'(bus.overrun), 0);
        wait_idle(1300);
        chk("ff_busy_cycles", busy_cnt, COLS * ROWS);
        chk("sb_empty2", 32'(sb.size()), 0);
        send(C_UP);
        repeat (5) send(C_RIGHT);
        cur("pre_scroll", 5, 29);
        busy_cnt = 0;
        if (SCR) for (int i = 0; i < COLS; i++) push(i, 8'h00);
        send(C_CR);
        cur("cr_last", 0, SCR ? 29 : 0);
        chk("cr_top", 32'(bus.top_row), SCR ? 1 : 0);
        chk("cr_busy", 32'(bus.busy), SCR ? 1 : 0);
        wait_idle(100);
        chk("cr_busy_cycles", busy_cnt, SCR ? COLS : 0);
        chk("sb_empty3", 32'(sb.size()), 0);
        push(0, 8'h51);
        send(8'h51);
        cur("q", 1, SCR ? 29 : 0);
        if (!SCR) send(C_UP);
        repeat (38) send(C_RIGHT);
        cur("pre_r", 39, 29);
        busy_cnt = 0;
        push(SCR ? 39 : 1199, 8'h52);
        if (SCR) for (int i = 40; i < 80; i++) push(i, 8'h00);
        send(8'h52);
        tick();
        wait_idle(100);
        tick();
        cur("r", 0, SCR ? 29 : 0);
        chk("r_top", 32'(bus.top_row), SCR ? 2 : 0);
        chk("r_busy_cycles", busy_cnt, SCR ? COLS : 0);
        chk("sb_empty4", 32'(sb.size()), 0);
        for (int i = 0; i < COLS * ROWS; i++) push(i, 8'h00);
        send(C_FF);
        repeat (50) tick();
        rstn = 1'b0;
        tick();
        sb.delete();
        chk("mid_rst_write", 32'(bus.write), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_addr", 32'(bus.addr_vram), 0);
        chk("mid_rst_char", 32'(bus.character), 0);
        chk("mid_rst_top", 32'(bus.top_row), 0);
        cur("mid_rst", 0, 0);
        rstn = 1'b1;
        repeat (3) tick();
        chk("post_rst_write", 32'(bus.write), 0);
        chk("post_rst_busy", 32'(bus.busy), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
